// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: load-use / write-back stalls, branch and jump flushes, memory freeze.
// Optional build macro RF_BYPASS_EN: write-back hazards are bypassed via fwd_a/fwd_b instead of stalling.
module id_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  id_op,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_wr_reg,
    input  logic        ext_stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        fwd_a,
    output logic        fwd_b,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        FREEZE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic        cnt_inc;

    logic uses_rt;
    logic lu_haz;
    logic wb_rs_hit;
    logic wb_rt_hit;
    logic wb_haz;
    logic wb_stall;
    logic jmp;
    logic fwd_a_c;
    logic fwd_b_c;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign uses_rt = (id_op == 6'h00) || (id_op == 6'h04) ||
                     (id_op == 6'h05) || (id_op == 6'h2B);

    // Register 0 is hardwired zero, so it never creates a dependency.
    assign lu_haz = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

    assign wb_rs_hit = wb_reg_write && (wb_wr_reg != 5'd0) && (wb_wr_reg == id_rs);
    assign wb_rt_hit = wb_reg_write && (wb_wr_reg != 5'd0) && uses_rt && (wb_wr_reg == id_rt);
    assign wb_haz    = wb_rs_hit || wb_rt_hit;
    assign jmp       = (id_op == 6'h02) || (id_op == 6'h03);

`ifdef RF_BYPASS_EN
    assign wb_stall = 1'b0;
    assign fwd_a_c  = wb_rs_hit;
    assign fwd_b_c  = wb_rt_hit;
`else
    assign wb_stall = wb_haz;
    assign fwd_a_c  = 1'b0;
    assign fwd_b_c  = 1'b0;
`endif

    // Priority chain; a jump waiting behind a stall or freeze flushes once it wins.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a       = fwd_a_c;
        fwd_b       = fwd_b_c;
        state_d     = RUN;
        cnt_inc     = 1'b0;
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fwd_a       = 1'b0;
            fwd_b       = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = FLUSH;
        end else if (ext_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            state_d     = FREEZE;
        end else if (lu_haz || wb_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = STALL;
            cnt_inc     = 1'b1;
        end else if (jmp) begin
            ifid_flush  = 1'b1;
            state_d     = FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            if (cnt_inc) begin
                cnt_q <= sat_inc(cnt_q);
            end
        end
    end

    assign state       = state_q;
    assign stall_count = cnt_q;

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst  in  1  synchronous active-low reset, sampled only on the rising edge of clk.
REQ-003 SHALL have: id_op in 6, id_rs in 5, id_rt in 5. These are the decode-stage instruction fields.
REQ-004 SHALL have: ex_mem_read in 1, ex_rt in 5. These identify a load in EX and its destination register.
REQ-005 SHALL have: ex_branch_taken in 1. This is a branch resolved as taken in EX.
REQ-006 SHALL have: wb_reg_write in 1, wb_wr_reg in 5. These describe the register-file write port in the current cycle.
REQ-007 SHALL have: ext_stall in 1. This is a freeze request from memory.
REQ-008 SHALL have the pipeline control outputs pc_write out 1, ifid_write out 1, ifid_flush out 1 and idex_bubble out 1.
REQ-009 SHALL have the bypass selects fwd_a out 1 and fwd_b out 1. These select writeData instead of RD1/RD2.
REQ-010 SHALL have the status outputs state out 2 and stall_count out 16.

Function
REQ-011 SHALL compute uses_rt = 1 for id_op in {0x00, 0x04, 0x05, 0x2B}, else 0.
REQ-012 SHALL define lu_haz as ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (uses_rt && ex_rt==id_rt)).
REQ-013 SHALL define wb_haz as wb_reg_write && wb_wr_reg!=0 && (wb_wr_reg==id_rs || (uses_rt && wb_wr_reg==id_rt)).
REQ-014 SHALL define jmp as id_op in {0x02, 0x03}.
REQ-015 SHALL drive all control outputs combinationally in the same cycle, using the fixed priority: branch > ext_stall > lu_haz > wb_haz (only when the bypass is absent) > jmp > normal.
REQ-016 On branch, SHALL drive pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
REQ-017 On ext_stall, SHALL drive pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0. All stages freeze.
REQ-018 On lu_haz or wb_haz stall, SHALL drive pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
REQ-019 On jmp, SHALL drive pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0.
REQ-020 Under normal conditions, SHALL drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-021 SHALL encode state as RUN=0, STALL=1, FLUSH=2, FREEZE=3, registered on each edge from the winning cause of that cycle. Branch or jmp gives FLUSH, ext_stall gives FREEZE, a hazard stall gives STALL, otherwise RUN.
REQ-022 SHALL increment stall_count by 1 on each edge where a lu_haz or wb_haz stall wins. It saturates at 0xFFFF. ext_stall cycles are not counted.
REQ-023 A jmp held in ID during a stall SHALL be deferred: ifid_flush asserts only in the first cycle in which no higher-priority cause is active.
REQ-024 When ex_branch_taken coincides with lu_haz, SHALL apply the flush with no stall, and stall_count SHALL NOT increment.
REQ-025 SHALL never flag a hazard on register 0.

Reset
REQ-026 While rst=0 at an edge, SHALL set state=RUN and stall_count=0.
REQ-027 While rst=0, SHALL force the combinational outputs to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, fwd_a=0, fwd_b=0.
REQ-028 Reset asserted in the middle of a stall SHALL discard the stall. The first cycle after release evaluates from RUN.

Configuration
REQ-029 Macro RF_BYPASS_EN defined: wb_haz SHALL NOT stall.
REQ-030 Macro RF_BYPASS_EN defined: fwd_a SHALL equal wb_haz-match on rs, and fwd_b SHALL equal wb_haz-match on rt with uses_rt. Both are combinational.
REQ-031 Macro RF_BYPASS_EN undefined: fwd_a and fwd_b SHALL be constant 0, and wb_haz SHALL stall per REQ-018.

Verification
REQ-032 Scenario 1: ex_mem_read=1, ex_rt=5, id_op=0, id_rs=5 -> one cycle with pc_write=0, idex_bubble=1. Next cycle state=STALL and stall_count=1.
REQ-033 Scenario 2: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall. Outputs normal and state=RUN.
REQ-034 Scenario 3: ex_branch_taken=1 and lu_haz in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1. stall_count unchanged.
REQ-035 Scenario 4: id_op=0x02 with ext_stall=1 for 3 cycles -> ifid_flush=0 during those 3 cycles. ifid_flush=1 in the 4th cycle.
REQ-036 Scenario 5: wb_reg_write=1, wb_wr_reg=9, id_rt=9, id_op=0x2B -> with the macro, fwd_b=1 and no stall. Without the macro, a one-cycle stall with fwd_b=0.
REQ-037 Scenario 6: 0x10000 consecutive load-use cycles, then rst=0 for one edge -> stall_count saturates at 0xFFFF. After reset, stall_count=0 and state=RUN.
